// File: rtl/register_bank_sweep.sv
// Flip-flop register bank with one write port, one registered read port
// and a clear/preset sweep sequencer that fills one word per qualified cycle.
module register_bank_sweep #(
    parameter int NrOfBits  = 8,
    parameter int NrOfWords = 16,
    parameter int AddrBits  = 4
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                ClockEnable,
    input  logic                Tick,
    input  logic                we,
    input  logic [AddrBits-1:0] waddr,
    input  logic [NrOfBits-1:0] D,
    input  logic                re,
    input  logic [AddrBits-1:0] raddr,
    input  logic                clr,
    input  logic                pre,
    input  logic                cs,
    output logic [NrOfBits-1:0] Q,
    output logic                Qvalid,
    output logic                busy,
    output logic                done,
    output logic                wr_rej
);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    localparam logic [AddrBits-1:0] LastAddr = AddrBits'(NrOfWords - 1);

    state_t                state_q, state_d;
    logic [AddrBits-1:0]   ptr_q, ptr_d;
    logic                  fill_q, fill_d;
    logic                  done_q, done_d;
    logic                  rej_q, rej_d;
    logic [NrOfBits-1:0]   q_q;
    logic                  qvalid_q;
    logic [NrOfBits-1:0]   mem [NrOfWords];

    logic                  qc;
    logic                  wr_en;
    logic [AddrBits-1:0]   wr_addr;
    logic [NrOfBits-1:0]   wr_data;

    assign qc = ClockEnable & Tick;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        fill_d  = fill_q;
        done_d  = 1'b0;
        rej_d   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = waddr;
        wr_data = D;
        if (qc) begin
            unique case (state_q)
                IDLE: begin
                    if (pre | clr) begin
                        state_d = SWEEP;
                        fill_d  = pre;
                        ptr_d   = '0;
                        rej_d   = we;
                    end else begin
                        wr_en = we;
                    end
                end
                SWEEP: begin
                    wr_en   = 1'b1;
                    wr_addr = ptr_q;
                    wr_data = {NrOfBits{fill_q}};
                    rej_d   = we;
                    if (ptr_q == LastAddr) begin
                        state_d = IDLE;
                        ptr_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // Read uses pre-edge contents, so same-cycle writes are read-first
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            fill_q   <= 1'b0;
            done_q   <= 1'b0;
            rej_q    <= 1'b0;
            q_q      <= '0;
            qvalid_q <= 1'b0;
            for (int i = 0; i < NrOfWords; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            fill_q   <= fill_d;
            done_q   <= done_d;
            rej_q    <= rej_d;
            qvalid_q <= qc & re;
            if (qc & re) begin
                q_q <= mem[raddr];
            end
            if (wr_en) begin
                mem[wr_addr] <= wr_data;
            end
        end
    end

    assign Q      = cs ? '0 : q_q;
    assign Qvalid = qvalid_q & ~cs;
    assign busy   = (state_q == SWEEP);
    assign done   = done_q;
    assign wr_rej = rej_q;

endmodule

// File: tb/tb_register_bank_sweep.sv
// Self-checking bench for register_bank_sweep (8-bit x 4 words):
// directed scenarios plus randomized traffic against a behavioural model.
module tb_register_bank_sweep;

    localparam int NB = 8;
    localparam int NW = 4;
    localparam int AB = 2;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          ClockEnable;
    logic          Tick;
    logic          we;
    logic [AB-1:0] waddr;
    logic [NB-1:0] D;
    logic          re;
    logic [AB-1:0] raddr;
    logic          clr;
    logic          pre;
    logic          cs;
    logic [NB-1:0] Q;
    logic          Qvalid;
    logic          busy;
    logic          done;
    logic          wr_rej;

    int vec = 0;
    int err = 0;

    register_bank_sweep #(.NrOfBits(NB), .NrOfWords(NW), .AddrBits(AB)) dut (
        .Clock(Clock), .Reset(Reset), .ClockEnable(ClockEnable), .Tick(Tick),
        .we(we), .waddr(waddr), .D(D), .re(re), .raddr(raddr),
        .clr(clr), .pre(pre), .cs(cs), .Q(Q), .Qvalid(Qvalid),
        .busy(busy), .done(done), .wr_rej(wr_rej)
    );

    always #5 Clock = ~Clock;

    // behavioural model: memory array plus a "words remaining" sweep job
    logic [NB-1:0] m_mem [NW];
    logic [NB-1:0] m_q;
    logic          m_qv, m_done, m_rej;
    int            m_left;
    int            m_next;
    logic [NB-1:0] m_fill;

    function automatic void model_edge();
        logic [NB-1:0] old [NW];
        if (Reset) begin
            foreach (m_mem[i]) m_mem[i] = '0;
            m_q = '0; m_qv = 0; m_done = 0; m_rej = 0;
            m_left = 0; m_next = 0; m_fill = '0;
            return;
        end
        m_qv = 0; m_done = 0; m_rej = 0;
        if (!(ClockEnable && Tick)) return;
        old = m_mem;
        if (re) begin
            m_q  = old[raddr];
            m_qv = 1;
        end
        if (m_left > 0) begin
            m_mem[m_next] = m_fill;
            m_next = m_next + 1;
            m_left = m_left - 1;
            m_rej  = we;
            if (m_left == 0) m_done = 1;
        end else if (pre || clr) begin
            m_fill = pre ? 8'hFF : 8'h00;
            m_left = NW;
            m_next = 0;
            m_rej  = we;
        end else if (we) begin
            m_mem[waddr] = D;
        end
    endfunction

    task automatic tick_clk();
        @(posedge Clock);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        Reset = 0; ClockEnable = 1; Tick = 1; we = 0; waddr = '0; D = '0;
        re = 0; raddr = '0; clr = 0; pre = 0; cs = 0;
    endtask

    task automatic do_read(input logic [AB-1:0] a,
                           output logic [NB-1:0] q, output logic qv);
        re = 1; raddr = a;
        tick_clk();
        q = Q; qv = Qvalid;
        re = 0;
    endtask

    task automatic do_write(input logic [AB-1:0] a, input logic [NB-1:0] d);
        we = 1; waddr = a; D = d;
        tick_clk();
        we = 0;
    endtask

    task automatic run_sweep(input logic p);
        pre = p; clr = ~p;
        tick_clk();
        pre = 0; clr = 0;
        repeat (NW + 1) tick_clk();
    endtask

    task automatic test_reset();
        logic [NB-1:0] q;
        logic qv;
        idle_inputs();
        Reset = 1; we = 1; waddr = 2'd3; D = 8'hAB; re = 1; pre = 1;
        tick_clk();
        tick_clk();
        vec++; if (Q !== 8'h00) begin err++; $display("FAIL rst_q got %h exp 00", Q); end
        vec++; if (Qvalid !== 1'b0) begin err++; $display("FAIL rst_qvalid got %b exp 0", Qvalid); end
        vec++; if (busy !== 1'b0) begin err++; $display("FAIL rst_busy got %b exp 0", busy); end
        vec++; if (done !== 1'b0 || wr_rej !== 1'b0) begin
            err++; $display("FAIL rst_pulses got done=%b rej=%b exp 0 0", done, wr_rej);
        end
        idle_inputs();
        do_read(2'd3, q, qv);
        vec++; if (q !== 8'h00) begin err++; $display("FAIL rst_word3 got %h exp 00", q); end
    endtask

    task automatic test_write_read();
        logic [NB-1:0] q;
        logic qv;
        do_write(2'd2, 8'h5A);
        do_read(2'd2, q, qv);
        vec++; if (q !== 8'h5A || qv !== 1'b1) begin
            err++; $display("FAIL wr_rd got q=%h v=%b exp 5a 1", q, qv);
        end
        tick_clk();
        vec++; if (Qvalid !== 1'b0 || Q !== 8'h5A) begin
            err++; $display("FAIL q_hold got q=%h v=%b exp 5a 0", Q, Qvalid);
        end
        do_read(2'd1, q, qv);
        vec++; if (q !== 8'h00) begin err++; $display("FAIL rd_addr1 got %h exp 00", q); end
    endtask

    task automatic test_sweep();
        logic [NB-1:0] q;
        logic qv;
        int bc, dc;
        pre = 1;
        tick_clk();
        pre = 0;
        bc = busy; dc = 0;
        for (int i = 0; i < 7; i++) begin
            tick_clk();
            bc += busy; dc += done;
        end
        vec++; if (bc !== 4) begin err++; $display("FAIL pre_busy_len got %0d exp 4", bc); end
        vec++; if (dc !== 1) begin err++; $display("FAIL pre_done_cnt got %0d exp 1", dc); end
        for (int a = 0; a < NW; a++) begin
            do_read(AB'(a), q, qv);
            vec++; if (q !== 8'hFF) begin err++; $display("FAIL pre_word%0d got %h exp ff", a, q); end
        end
        run_sweep(1'b0);
        for (int a = 0; a < NW; a++) begin
            do_read(AB'(a), q, qv);
            vec++; if (q !== 8'h00) begin err++; $display("FAIL clr_word%0d got %h exp 00", a, q); end
        end
    endtask

    task automatic test_reject();
        logic [NB-1:0] q;
        logic qv;
        do_write(2'd1, 8'h77);
        clr = 1;
        tick_clk();
        clr = 0;
        we = 1; waddr = 2'd1; D = 8'h11;
        tick_clk();
        we = 0;
        vec++; if (wr_rej !== 1'b1) begin err++; $display("FAIL sweep_rej got %b exp 1", wr_rej); end
        tick_clk();
        vec++; if (wr_rej !== 1'b0) begin err++; $display("FAIL rej_pulse got %b exp 0", wr_rej); end
        repeat (4) tick_clk();
        do_read(2'd1, q, qv);
        vec++; if (q !== 8'h00) begin err++; $display("FAIL rej_word1 got %h exp 00", q); end
        clr = 1; pre = 1; we = 1; waddr = 2'd2; D = 8'h12;
        tick_clk();
        clr = 0; pre = 0; we = 0;
        vec++; if (wr_rej !== 1'b1 || busy !== 1'b1) begin
            err++; $display("FAIL accept_rej got rej=%b busy=%b exp 1 1", wr_rej, busy);
        end
        repeat (NW + 1) tick_clk();
        do_read(2'd2, q, qv);
        vec++; if (q !== 8'hFF) begin err++; $display("FAIL both_fill got %h exp ff", q); end
    endtask

    task automatic test_read_first();
        logic [NB-1:0] q;
        logic qv;
        run_sweep(1'b0);
        we = 1; waddr = 2'd0; D = 8'h33; re = 1; raddr = 2'd0;
        tick_clk();
        we = 0; re = 0;
        vec++; if (Q !== 8'h00 || Qvalid !== 1'b1) begin
            err++; $display("FAIL rd_first got q=%h v=%b exp 00 1", Q, Qvalid);
        end
        do_read(2'd0, q, qv);
        vec++; if (q !== 8'h33) begin err++; $display("FAIL rd_after got %h exp 33", q); end
    endtask

    task automatic test_tick_gaps();
        logic [NB-1:0] q;
        logic qv;
        logic [NB-1:0] exp_rd [3];
        int bc, dc, k;
        exp_rd[0] = 8'h00; exp_rd[1] = 8'hFF; exp_rd[2] = 8'h00;
        run_sweep(1'b0);
        bc = 0; dc = 0; k = 0;
        for (int c = 0; c < 21; c++) begin
            Tick = (c % 3 == 0);
            pre  = (c == 0);
            re   = (c == 6 || c == 9 || c == 12);
            raddr = (c == 12) ? 2'd3 : 2'd1;
            tick_clk();
            bc += busy; dc += done;
            if (c == 6 || c == 9 || c == 12) begin
                vec++; if (Q !== exp_rd[k] || Qvalid !== 1'b1) begin
                    err++; $display("FAIL gap_rd%0d got q=%h v=%b exp %h 1", c, Q, Qvalid, exp_rd[k]);
                end
                k++;
            end
        end
        Tick = 1; pre = 0; re = 0;
        vec++; if (bc !== 12) begin err++; $display("FAIL gap_busy_len got %0d exp 12", bc); end
        vec++; if (dc !== 1) begin err++; $display("FAIL gap_done_cnt got %0d exp 1", dc); end
        cs = 1;
        do_read(2'd2, q, qv);
        vec++; if (q !== 8'h00 || qv !== 1'b0) begin
            err++; $display("FAIL cs_gate got q=%h v=%b exp 00 0", q, qv);
        end
        cs = 0;
        #1;
        vec++; if (Q !== 8'hFF) begin err++; $display("FAIL cs_drop got %h exp ff", Q); end
    endtask

    task automatic test_reset_sweep();
        logic [NB-1:0] q;
        logic qv;
        int dc;
        pre = 1;
        tick_clk();
        pre = 0;
        tick_clk();
        Reset = 1;
        tick_clk();
        Reset = 0;
        vec++; if (busy !== 1'b0) begin err++; $display("FAIL abort_busy got %b exp 0", busy); end
        dc = done;
        repeat (5) begin
            tick_clk();
            dc += done;
        end
        vec++; if (dc !== 0) begin err++; $display("FAIL abort_done got %0d exp 0", dc); end
        for (int a = 0; a < NW; a++) begin
            do_read(AB'(a), q, qv);
            vec++; if (q !== 8'h00) begin err++; $display("FAIL abort_word%0d got %h exp 00", a, q); end
        end
    endtask

    task automatic test_random();
        logic [NB-1:0] eq;
        for (int i = 0; i < 400; i++) begin
            Reset = ($urandom_range(0, 39) == 0);
            ClockEnable = ($urandom_range(0, 5) != 0);
            Tick = ($urandom_range(0, 3) != 0);
            we = $urandom_range(0, 1); waddr = AB'($urandom_range(0, NW - 1));
            D = NB'($urandom);
            re = $urandom_range(0, 1); raddr = AB'($urandom_range(0, NW - 1));
            clr = ($urandom_range(0, 11) == 0);
            pre = ($urandom_range(0, 11) == 0);
            cs = ($urandom_range(0, 4) == 0);
            tick_clk();
            eq = cs ? 8'h00 : m_q;
            vec++; if (Q !== eq || Qvalid !== (m_qv & ~cs)) begin
                err++; $display("FAIL rnd_q cyc %0d got q=%h v=%b exp %h %b", i, Q, Qvalid, eq, m_qv & ~cs);
            end
            vec++; if (busy !== (m_left > 0) || done !== m_done || wr_rej !== m_rej) begin
                err++; $display("FAIL rnd_status cyc %0d got b=%b d=%b r=%b exp %b %b %b",
                                i, busy, done, wr_rej, m_left > 0, m_done, m_rej);
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_write_read();
        test_sweep();
        test_reject();
        test_read_first();
        test_tick_gaps();
        test_reset_sweep();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
